// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with iterative multiply/divide.
//
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL) finish one edge
// after acceptance. MULT/MULTU use shift-add and DIV/DIVU use restoring
// division. Each of these handles one bit per cycle, then spends one cycle on
// the sign fix. HI/LO hold the 2*WIDTH multiply result, or the
// remainder/quotient of a divide.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           request, accepted when busy=0 (also in the DONE cycle)
//   op[3:0]         operation select; 12-15 behave as ADD with overflow=0
//   in1, in2, imm   operand A, operand B, immediate (sign-extended)
//   use_imm         1: operand B = sign-extended imm
//   out             result (equals lo for mul/div), held between valids
//   hi, lo          mul high/low word, div remainder/quotient
//   zero            out==0, updated with out
//   overflow        signed overflow for ADD/SUB
//   div_by_zero     DIV/DIVU with B==0
//   busy            iterative op in progress
//   valid           one-cycle pulse when out/hi/lo/flags update
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [IMM_W-1:0] imm,
  input  logic             use_imm,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy,
  output logic             valid
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_r;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, m_r;
  logic [2*WIDTH-1:0] acc_r;        // {hi, lo} working register for mul/div
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_lo_r, neg_hi_r, dbz_r;

  logic [WIDTH-1:0]   b_sel_s, mag_a_s, mag_b_s, alu_s;
  logic               sign_a_s, sign_b_s, alu_ovf_s, accept_s;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s, rem_diff_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, mul_fix_s, div_fix_s;

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

  // Operand B selection and operand magnitudes for signed mul/div.
  always_comb begin
    b_sel_s  = in2;
    sign_a_s = 1'b0;
    sign_b_s = 1'b0;
    if (use_imm) begin
      b_sel_s = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin
      b_sel_s = in2;
    end
    if ((op == OP_MULT) || (op == OP_DIV)) begin
      sign_a_s = in1[WIDTH-1];
      sign_b_s = b_sel_s[WIDTH-1];
    end else begin
      sign_a_s = 1'b0;
      sign_b_s = 1'b0;
    end
    mag_a_s = sign_a_s ? -in1 : in1;
    mag_b_s = sign_b_s ? -b_sel_s : b_sel_s;
  end

  // Single-cycle result from the latched operands.
  always_comb begin
    alu_s     = a_r + b_r;
    alu_ovf_s = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_s     = a_r + b_r;
        alu_ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (alu_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        alu_s     = a_r - b_r;
        alu_ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (alu_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_AND:  alu_s = a_r & b_r;
      OP_OR:   alu_s = a_r | b_r;
      OP_XOR:  alu_s = a_r ^ b_r;
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SLL:  alu_s = a_r << b_r[SH_W-1:0];
      OP_SRL:  alu_s = a_r >> b_r[SH_W-1:0];
      default: begin
        alu_s     = a_r + b_r;
        alu_ovf_s = 1'b0;
      end
    endcase
  end

  // One iteration of shift-add multiply and restoring divide, plus the sign fixes.
  always_comb begin
    // Multiplier sits in the low half; partial product accumulates in the high half.
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    // Remainder in the high half; dividend bits shift out of the low half.
    rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    rem_diff_s = rem_sh_s - {1'b0, m_r};
    if (rem_diff_s[WIDTH]) begin
      div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {rem_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
    mul_fix_s = neg_lo_r ? -acc_r : acc_r;
    div_fix_s = {(neg_hi_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH]),
                 (neg_lo_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0])};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      op_r        <= 4'd0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      m_r         <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      neg_lo_r    <= 1'b0;
      neg_hi_r    <= 1'b0;
      dbz_r       <= 1'b0;
      out         <= {WIDTH{1'b0}};
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_r)
        IDLE: state_r <= IDLE;
        MUL, DIV: begin
          if (cnt_r == CNT_LAST) begin
            acc_r   <= (state_r == MUL) ? mul_fix_s : div_fix_s;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            acc_r <= (state_r == MUL) ? mul_next_s : div_next_s;
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          valid   <= 1'b1;
          state_r <= IDLE;
          if ((op_r >= OP_MULT) && (op_r <= OP_DIVU)) begin
            hi          <= acc_r[2*WIDTH-1:WIDTH];
            lo          <= acc_r[WIDTH-1:0];
            out         <= acc_r[WIDTH-1:0];
            zero        <= (acc_r[WIDTH-1:0] == {WIDTH{1'b0}});
            overflow    <= 1'b0;
            div_by_zero <= dbz_r;
          end else begin
            out         <= alu_s;
            zero        <= (alu_s == {WIDTH{1'b0}});
            overflow    <= alu_ovf_s;
            div_by_zero <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase

      // Accepting a request overrides the IDLE/DONE next-state chosen above.
      if (accept_s) begin
        op_r     <= op;
        a_r      <= in1;
        b_r      <= b_sel_s;
        cnt_r    <= {CNT_W{1'b0}};
        neg_lo_r <= sign_a_s ^ sign_b_s;
        neg_hi_r <= sign_a_s;
        dbz_r    <= 1'b0;
        case (op)
          OP_MULT, OP_MULTU: begin
            m_r     <= mag_a_s;
            acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
            busy    <= 1'b1;
            state_r <= MUL;
          end
          OP_DIV, OP_DIVU: begin
            if (b_sel_s == {WIDTH{1'b0}}) begin
              acc_r   <= {in1, {WIDTH{1'b1}}};
              dbz_r   <= 1'b1;
              state_r <= DONE;
            end else begin
              m_r     <= mag_b_s;
              acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
              busy    <= 1'b1;
              state_r <= DIV;
            end
          end
          default: state_r <= DONE;
        endcase
      end else begin
        op_r <= op_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] in1 = 32'd0, in2 = 32'd0;
  logic [15:0] imm = 16'd0;
  logic        use_imm = 1'b0;
  logic [31:0] out, hi, lo;
  logic        zero, overflow, div_by_zero, busy, valid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int bcnt = 0;

  alu_seq #(.WIDTH(32), .IMM_W(16), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .imm(imm), .use_imm(use_imm), .out(out), .hi(hi), .lo(lo), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request; it is accepted at the next rising edge. Inputs are
  // scrambled afterwards to show that the operands were latched.
  task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] i, input logic ui);
    @(negedge clk);
    op = o; in1 = a; in2 = b; imm = i; use_imm = ui; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678; op = 4'd15; imm = 16'h5A5A;
    bcnt = busy ? 1 : 0;
    cyc = 0;
  endtask

  task automatic wait_valid(input int max_c);
    while (cyc < max_c) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) bcnt++;
      if (valid) break;
    end
    chk("valid_seen", {31'd0, valid}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_hilo", {hi[15:0], lo[15:0]}, 32'd0);
    chk("rst_busy_valid", {30'd0, busy, valid}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // ADD overflow
    start_op(4'd0, 32'h7FFF_FFFF, 32'd1, 16'd0, 1'b0);
    wait_valid(4);
    chk("add_lat", cyc, 32'd1);
    chk("add_out", out, 32'h8000_0000);
    chk("add_flags", {29'd0, overflow, zero, div_by_zero}, 32'h4);

    // ADD with sign-extended immediate
    start_op(4'd0, 32'd5, 32'd100, 16'hFFFF, 1'b1);
    wait_valid(4);
    chk("addi_out", out, 32'd4);
    chk("addi_ovf", {31'd0, overflow}, 32'd0);

    // SUB 9-9
    start_op(4'd1, 32'd9, 32'd9, 16'd0, 1'b0);
    wait_valid(4);
    chk("sub_out", out, 32'd0);
    chk("sub_flags", {30'd0, zero, overflow}, 32'h2);
    chk("sub_hilo_kept", lo, 32'd0);

    // SUB overflow
    start_op(4'd1, 32'h8000_0000, 32'd1, 16'd0, 1'b0);
    wait_valid(4);
    chk("subov_out", out, 32'h7FFF_FFFF);
    chk("subov_ovf", {31'd0, overflow}, 32'd1);

    // MULT -3 x 5
    start_op(4'd8, 32'hFFFF_FFFD, 32'd5, 16'd0, 1'b0);
    wait_valid(40);
    chk("mult_lat", cyc, 32'd34);
    chk("mult_busy", bcnt, 32'd33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("mult_out", out, 32'hFFFF_FFF1);
    chk("mult_ovf", {31'd0, overflow}, 32'd0);

    // AND keeps hi/lo
    start_op(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 16'd0, 1'b0);
    wait_valid(4);
    chk("and_out", out, 32'h0000_F000);
    chk("and_hi_kept", hi, 32'hFFFF_FFFF);
    chk("and_lo_kept", lo, 32'hFFFF_FFF1);

    // MULTU
    start_op(4'd9, 32'hFFFF_FFFF, 32'd2, 16'd0, 1'b0);
    wait_valid(40);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7/2
    start_op(4'd10, 32'hFFFF_FFF9, 32'd2, 16'd0, 1'b0);
    wait_valid(40);
    chk("div_lat", cyc, 32'd34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 7/0
    start_op(4'd11, 32'd7, 32'd0, 16'd0, 1'b0);
    wait_valid(4);
    chk("dbz_lat", cyc, 32'd1);
    chk("dbz_busy", bcnt, 32'd0);
    chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    chk("dbz_lo", lo, 32'hFFFF_FFFF);
    chk("dbz_hi", hi, 32'd7);

    // SLT / SLL / SRL / XOR
    start_op(4'd5, 32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0);
    wait_valid(4);
    chk("slt_out", out, 32'd1);
    chk("slt_dbz_clr", {31'd0, div_by_zero}, 32'd0);
    start_op(4'd6, 32'd1, 32'd33, 16'd0, 1'b0);
    wait_valid(4);
    chk("sll_out", out, 32'd2);
    start_op(4'd7, 32'h8000_0000, 32'd4, 16'd0, 1'b0);
    wait_valid(4);
    chk("srl_out", out, 32'h0800_0000);
    start_op(4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 16'd0, 1'b0);
    wait_valid(4);
    chk("xor_out", out, 32'hF0F0_F0F0);

    // DIV MIN / -1
    start_op(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 16'd0, 1'b0);
    wait_valid(40);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'd0);
    chk("divmin_dbz", {31'd0, div_by_zero}, 32'd0);

    // Reserved op behaves as ADD without overflow
    start_op(4'd12, 32'h7FFF_FFFF, 32'd1, 16'd0, 1'b0);
    wait_valid(4);
    chk("rsv_out", out, 32'h8000_0000);
    chk("rsv_ovf", {31'd0, overflow}, 32'd0);

    // start during MULT is ignored
    start_op(4'd8, 32'd6, 32'd7, 16'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); op = 4'd0; in1 = 32'd1; in2 = 32'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_valid(40);
    chk("midmul_lo", lo, 32'd42);
    chk("midmul_hi", hi, 32'd0);
    chk("midmul_out", out, 32'd42);
    @(posedge clk); #1;
    chk("midmul_noqueue", {30'd0, busy, valid}, 32'd0);

    // Back-to-back start in the DONE cycle
    start_op(4'd3, 32'h0000_000F, 32'h0000_00F0, 16'd0, 1'b0);
    @(negedge clk); op = 4'd4; in1 = 32'h0000_00FF; in2 = 32'h0000_000F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_first", {valid, out[30:0]}, {1'b1, 31'h0000_00FF});
    @(posedge clk); #1;
    chk("b2b_second", {valid, out[30:0]}, {1'b1, 31'h0000_00F0});

    // Reset mid-DIV
    start_op(4'd10, 32'd100, 32'd7, 16'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rstdiv_out", out, 32'd0);
    chk("rstdiv_lo", lo, 32'd0);
    chk("rstdiv_hi", hi, 32'd0);
    chk("rstdiv_flags", {27'd0, zero, overflow, div_by_zero, busy, valid}, 32'd0);
    @(negedge clk); reset = 1'b0;
    start_op(4'd0, 32'd2, 32'd3, 16'd0, 1'b0);
    wait_valid(4);
    chk("post_rst_add", out, 32'd5);
    chk("post_rst_lat", cyc, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle MIPS ALU.
- Adds iterative multiply/divide with HI/LO result registers, sign-extended immediate select, and a start/busy/valid handshake.
- Sits in the EX stage; the pipeline control stalls while busy=1.

Parameters:
WIDTH, 32, operand/result width in bits (>=8).
IMM_W, 16, immediate width; sign-extended to WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request; accepted only when busy=0.
op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU; 12-15 reserved.
in1  in  WIDTH  operand A.
in2  in  WIDTH  operand B.
imm  in  IMM_W  immediate.
use_imm  in  1  1: operand B = sign-extended imm.
out  out  WIDTH  result; equals lo for mul/div.
hi  out  WIDTH  MULT high word / DIV remainder.
lo  out  WIDTH  MULT low word / DIV quotient.
zero  out  1  out==0, registered with out.
overflow  out  1  signed overflow, ADD/SUB only.
div_by_zero  out  1  DIV/DIVU with B==0.
busy  out  1  iterative op in progress.
valid  out  1  one-cycle pulse; out/hi/lo/flags updated this cycle.

Behaviour:
- Reset (async): all outputs 0; FSM to IDLE; counter 0.
- Operand capture: at the accepting edge, A, B (or ext(imm)) and op are latched. Later input changes have no effect until the next accept.
- start while busy=1 is ignored; no queueing.
- FSM states:
  - IDLE: start with op 0-7 -> DONE, result computed combinationally from the latched values. start with op 8-11 and B!=0 -> MUL or DIV, counter=0, busy=1. start with DIV/DIVU and B==0 -> DONE with div_by_zero=1.
  - MUL: shift-add over |A|,|B| (MULT) or raw operands (MULTU); one bit per cycle. After WIDTH iterations, apply sign fix: negate the 2*WIDTH product if sign(A)^sign(B) for MULT -> DONE.
  - DIV: restoring division on magnitudes (DIV) or raw operands (DIVU); one quotient bit per cycle. After WIDTH iterations: quotient negated if sign(A)^sign(B); remainder takes the sign of A -> DONE.
  - DONE: valid=1 for exactly one cycle, busy=0, output registers loaded -> IDLE. A start in this cycle is accepted.
- Latency from the accepting edge:
  - ops 0-7 and divide-by-zero: valid at the next edge (1 cycle).
  - mul/div: busy high for WIDTH+1 cycles; valid at edge WIDTH+2.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; overflow when operand signs agree (after negating B for SUB) and the result sign differs.
  - SLT is a signed compare giving 0 or 1.
  - SLL/SRL shift A by B[log2(WIDTH)-1:0]; SRL is logical.
- Flag updates:
  - overflow and div_by_zero update on every valid; they are 0 for ops where they do not apply.
  - hi/lo update only on mul/div completion and keep their values across ops 0-7.
- Divide by zero: lo = all ones, hi = A, div_by_zero=1.
- Signed DIV of MIN by -1: lo = MIN, hi = 0, no flag.
- Reserved op: treated as ADD with overflow=0.
- out/zero hold their last value between valid pulses.

Test Plan:
- ADD, use_imm=0, in1=0x7FFFFFFF, in2=1 -> valid 1 cycle after start; out=0x80000000, overflow=1, zero=0.
- ADD, use_imm=1, in1=5, imm=0xFFFF -> out=4. Then SUB 9-9 -> out=0, zero=1, overflow=0.
- MULT -3 x 5 -> busy for 33 cycles; valid at edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> valid after 1 cycle; div_by_zero=1, lo=0xFFFFFFFF, hi=7, busy never set.
- start pulsed again mid-MULT with different op and operands -> ignored; original MULT result returned. Back-to-back start in the DONE cycle is accepted.
- reset asserted at iteration 10 of DIV -> all outputs 0 immediately; next ADD 2+3 completes normally with out=5.
